fifo_rl_axis: RTL and testbench



---
 rtl/axis_fifo_pkg.sv | 39 +++
 rtl/fifo_out_buf.sv | 73 +++++++
 rtl/fifo_rl_axis.sv | 100 ++++++++++
 tb/tb_fifo_rl_axis.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/axis_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axis_fifo_pkg: shared helpers for the AXIS data FIFO (gray coding, sizing) |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package axis_fifo_pkg;

  localparam int OUT_BUF_DEPTH = 2;
  localparam int PTR_MAX_W     = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic ptr_word_t width_mask(input int w);
    ptr_word_t m;
    m = '0;
    for (int i = 0; i < PTR_MAX_W; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic ptr_word_t bin2gray(input ptr_word_t b, input int w);
    ptr_word_t bm;
    bm = b & width_mask(w);
    return bm ^ (bm >> 1);
  endfunction

  function automatic ptr_word_t gray2bin(input ptr_word_t g, input int w);
    ptr_word_t b;
    b = g & width_mask(w);
    // Prefix XOR from the MSB down, done in log2 steps.
    for (int s = 1; s < PTR_MAX_W; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_out_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_out_buf: 2-entry first-word-fall-through skid buffer, AXIS master out |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fifo_out_buf
  import axis_fifo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic [1:0]       occ
);

  localparam logic [1:0] OCC_FULL = 2'(OUT_BUF_DEPTH);

  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [1:0]       occ_q, occ_d;
  logic             pop;

  assign pop           = (occ_q != 2'd0) && m_axis_tready;
  assign m_axis_tvalid = (occ_q != 2'd0);
  assign m_axis_tdata  = main_q;
  assign occ           = occ_q;

  // main always holds the oldest word; skid only fills behind it.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    occ_d  = occ_q;
    case ({s_valid, pop})
      2'b11: begin
        if (occ_q == OCC_FULL) begin
          main_d = skid_q;
          skid_d = s_data;
        end else begin
          main_d = s_data;
        end
      end
      2'b01: begin
        if (occ_q == OCC_FULL) main_d = skid_q;
        occ_d = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd0) main_d = s_data;
        else               skid_d = s_data;
        occ_d = occ_q + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
      occ_q  <= occ_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_rl_axis.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_rl_axis: AXIS FIFO read side - gray read pointer, empty, read issue,  |
// | FWFT output. Optional RD_LEVEL_EN adds the registered r_level output.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fifo_rl_axis
  import axis_fifo_pkg::*;
#(
  parameter  int FIFO_DEPTH = 16,
  parameter  int FIFO_WIDTH = 32,
  localparam int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic                  r_clk,
  input  logic                  rst_n,
  input  logic [AW:0]           wptr2rl,
  output logic [AW:0]           rptr2wl,
  output logic                  r_en,
  output logic [AW-1:0]         r_addr,
  input  logic [FIFO_WIDTH-1:0] r_data,
  output logic                  empty,
`ifdef RD_LEVEL_EN
  output logic [AW:0]           r_level,
`endif
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [FIFO_WIDTH-1:0] m_axis_tdata
);

  localparam logic [2:0] BUF_SLOTS = 3'(OUT_BUF_DEPTH);

  logic [AW:0] rptr_q, rptr_d;
  logic [AW:0] rgray_q, rgray_d;
  logic        infl_q, infl_d;
  logic [1:0]  occ;
  logic [2:0]  inuse;
  logic        pop;

  assign empty   = (rgray_q == wptr2rl);
  assign rptr2wl = rgray_q;
  assign r_addr  = rptr_q[AW-1:0];
  assign pop     = m_axis_tvalid && m_axis_tready;
  assign inuse   = {1'b0, occ} + {2'b00, infl_q};

  // A read may be issued into the last free slot only if a pop frees one now.
  always_comb begin
    r_en = 1'b0;
    if (!empty) begin
      r_en = (inuse < BUF_SLOTS) || (pop && (inuse == BUF_SLOTS));
    end
    rptr_d  = rptr_q + {{AW{1'b0}}, r_en};
    rgray_d = (AW+1)'(bin2gray(ptr_word_t'(rptr_d), AW + 1));
    infl_d  = r_en;
  end

  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q  <= '0;
      rgray_q <= '0;
      infl_q  <= 1'b0;
    end else begin
      rptr_q  <= rptr_d;
      rgray_q <= rgray_d;
      infl_q  <= infl_d;
    end
  end

  fifo_out_buf #(
    .WIDTH (FIFO_WIDTH)
  ) u_out_buf (
    .clk           (r_clk),
    .rst_n         (rst_n),
    .s_valid       (infl_q),
    .s_data        (r_data),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .occ           (occ)
  );

`ifdef RD_LEVEL_EN
  logic [AW:0] level_q, level_d;
  logic [AW:0] wbin;

  // Words not yet handed out: still in memory plus in flight plus buffered.
  always_comb begin
    wbin    = (AW+1)'(gray2bin(ptr_word_t'(wptr2rl), AW + 1));
    level_d = wbin - rptr_q + (AW+1)'(inuse);
  end

  always_ff @(posedge r_clk or negedge rst_n) begin
    if (!rst_n) level_q <= '0;
    else        level_q <= level_d;
  end

  assign r_level = level_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rl_axis.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fifo_rl_axis: directed + randomized bench for the FIFO read side        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_fifo_rl_axis;

  localparam int DEPTH = 16;
  localparam int WIDTH = 32;
  localparam int AW    = 4;

  logic              r_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [AW:0]       wptr2rl = '0;
  logic [AW:0]       rptr2wl;
  logic              r_en;
  logic [AW-1:0]     r_addr;
  logic [WIDTH-1:0]  r_data;
  logic              empty;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic [WIDTH-1:0]  m_axis_tdata;
`ifdef RD_LEVEL_EN
  logic [AW:0]       r_level;
`endif

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] exp_q [$];
  logic [AW:0]      wbin = '0;
  int               beats, beat_first, beat_last, cyc, ren_cnt, gray_bad, sent;
  bit               prev_stall, seen_wrap, last_ren, ok;
  logic [WIDTH-1:0] prev_data;
  logic [AW:0]      prev_gray;
  logic [AW-1:0]    last_raddr;

  fifo_rl_axis #(
    .FIFO_DEPTH (DEPTH),
    .FIFO_WIDTH (WIDTH)
  ) dut (
    .r_clk         (r_clk),
    .rst_n         (rst_n),
    .wptr2rl       (wptr2rl),
    .rptr2wl       (rptr2wl),
    .r_en          (r_en),
    .r_addr        (r_addr),
    .r_data        (r_data),
    .empty         (empty),
`ifdef RD_LEVEL_EN
    .r_level       (r_level),
`endif
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata)
  );

  always #5 r_clk = ~r_clk;

  // Synchronous-read memory: data appears the cycle after r_en.
  always @(posedge r_clk or negedge rst_n) begin
    if (!rst_n)    r_data <= '0;
    else if (r_en) r_data <= mem[r_addr];
  end

  function automatic logic [AW:0] g2b(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] d, output bit pushed);
    logic [AW:0] rbin;
    rbin   = g2b(rptr2wl);
    pushed = 1'b0;
    if (5'(wbin - rbin) != 5'(DEPTH)) begin
      mem[wbin[AW-1:0]] = d;
      exp_q.push_back(d);
      wbin    = wbin + 5'd1;
      wptr2rl = wbin ^ (wbin >> 1);
      pushed  = 1'b1;
    end
  endtask

  task automatic cycle(input bit rdy);
    m_axis_tready = rdy;
    #1;
    last_ren   = r_en;
    last_raddr = r_addr;
    if (r_en) begin
      ren_cnt++;
      chk("ren_while_empty", {63'd0, empty}, 64'd0);
    end
    if (prev_stall) begin
      chk("hold_valid", {63'd0, m_axis_tvalid}, 64'd1);
      chk("hold_data", {32'd0, m_axis_tdata}, {32'd0, prev_data});
    end
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        chk("beat_unexpected", {63'd0, m_axis_tvalid}, 64'd0);
      end else begin
        chk("beat_data", {32'd0, m_axis_tdata}, {32'd0, exp_q.pop_front()});
        beats++;
        if (beat_first < 0) beat_first = cyc;
        beat_last = cyc;
      end
    end
    if (rptr2wl != prev_gray) begin
      if ($countones(rptr2wl ^ prev_gray) != 1) gray_bad++;
      if (prev_gray == 5'b10000 && rptr2wl == 5'b00000) seen_wrap = 1'b1;
    end
    prev_gray  = rptr2wl;
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
    cyc++;
    @(negedge r_clk);
  endtask

  task automatic clear_stats();
    beats = 0; beat_first = -1; beat_last = -1; cyc = 0; ren_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wptr2rl = '0; wbin = '0; m_axis_tready = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("rst_tdata", {32'd0, m_axis_tdata}, 64'd0);
    chk("rst_rptr2wl", {59'd0, rptr2wl}, 64'd0);
    chk("rst_empty", {63'd0, empty}, 64'd1);
    chk("rst_ren", {63'd0, r_en}, 64'd0);
    @(negedge r_clk);
    @(negedge r_clk);
    rst_n = 1'b1;
    prev_stall = 1'b0; prev_gray = '0; seen_wrap = 1'b0; gray_bad = 0;
    clear_stats();
  endtask

  initial begin
    // 1: reset and idle
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0);
      chk("idle_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
      chk("idle_ren", {63'd0, last_ren}, 64'd0);
      chk("idle_rptr2wl", {59'd0, rptr2wl}, 64'd0);
      chk("idle_tdata", {32'd0, m_axis_tdata}, 64'd0);
    end

    // 2: single word, two-cycle first-word latency
    push(32'hA5A5_0001, ok);
    cycle(1'b1);
    chk("t2_ren", {63'd0, last_ren}, 64'd1);
    chk("t2_raddr", {60'd0, last_raddr}, 64'd0);
    chk("t2_tvalid_n1", {63'd0, m_axis_tvalid}, 64'd0);
    chk("t2_rptr2wl", {59'd0, rptr2wl}, 64'b00001);
    chk("t2_empty", {63'd0, empty}, 64'd1);
    cycle(1'b1);
    chk("t2_tvalid_n2", {63'd0, m_axis_tvalid}, 64'd1);
    chk("t2_tdata", {32'd0, m_axis_tdata}, 64'hA5A5_0001);
    cycle(1'b1);
    chk("t2_tvalid_after", {63'd0, m_axis_tvalid}, 64'd0);
    chk("t2_drained", 64'(exp_q.size()), 64'd0);

    // 3: 16-word stream with tready held high
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(32'(i), ok);
    for (int i = 0; i < 22; i++) cycle(1'b1);
    chk("t3_beats", 64'(beats), 64'd16);
    chk("t3_first_latency", 64'(beat_first), 64'd2);
    chk("t3_no_bubbles", 64'(beat_last - beat_first), 64'd15);

    // 4: backpressure then release
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(32'(i), ok);
    for (int i = 0; i < 6; i++) cycle(1'b0);
    chk("t4_ren_pulses", 64'(ren_cnt), 64'd2);
    chk("t4_rptr", {59'd0, g2b(rptr2wl)}, 64'd2);
    chk("t4_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
    chk("t4_tdata", {32'd0, m_axis_tdata}, 64'd0);
    clear_stats();
    for (int i = 0; i < 20; i++) cycle(1'b1);
    chk("t4_beats", 64'(beats), 64'd16);
    chk("t4_no_bubbles", 64'(beat_last - beat_first), 64'd15);

    // reset while words are buffered
    for (int i = 0; i < 3; i++) push(32'(100 + i), ok);
    for (int i = 0; i < 4; i++) cycle(1'b0);
    chk("midrst_tvalid_before", {63'd0, m_axis_tvalid}, 64'd1);
    do_reset();

    // 5: 40 words through the wrap with random tready
    sent = 0;
    for (int i = 0; i < 3000 && beats < 40; i++) begin
      if (sent < 40 && $urandom_range(0, 2) != 0) begin
        push($urandom, ok);
        if (ok) sent++;
      end
      cycle($urandom_range(0, 3) != 0);
    end
    chk("t5_beats", 64'(beats), 64'd40);
    chk("t5_leftover", 64'(exp_q.size()), 64'd0);
    chk("t5_wrap_seen", {63'd0, seen_wrap}, 64'd1);
    chk("t5_gray_one_bit", 64'(gray_bad), 64'd0);

`ifdef RD_LEVEL_EN
    // 6: registered level
    do_reset();
    for (int i = 0; i < 10; i++) push(32'(i), ok);
    for (int i = 0; i < 6; i++) cycle(1'b0);
    chk("t6_level10", {59'd0, r_level}, 64'(exp_q.size()));
    for (int i = 0; i < 3; i++) cycle(1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0);
    chk("t6_level7", {59'd0, r_level}, 64'(exp_q.size()));
    chk("t6_level7_abs", {59'd0, r_level}, 64'd7);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
